// File: rtl/tdc_pkg.sv
// ---- tdc_pkg : state encoding shared by run controller, datapath and benches  (rev 1.0) ----
`default_nettype none

package tdc_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_RUN   = 2'b01;
  localparam state_t ST_PAUSE = 2'b10;
  localparam state_t ST_DONE  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ---- btn_sync_edge : raw button synchronizer with one-cycle rising-edge pulse  (rev 1.0) ----
`default_nettype none

module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   last_d_q;
  logic                   last_d_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    last_d_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      last_d_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      last_d_q <= last_d_d;
    end
  end

  // A held button stays high in the chain, so only its first synchronized cycle pulses.
  assign pulse = sync_q[SYNC_STAGES-1] & ~last_d_q;

endmodule

`default_nettype wire

// File: rtl/tdc_run_ctrl.sv
// ---- tdc_run_ctrl : run/pause/clear sequencer for the 00..99 counter datapath  (rev 1.0) ----
`default_nettype none

module tdc_run_ctrl
  import tdc_pkg::*;
#(
  parameter int DIV         = 50_000_000,
  parameter int DIV_W       = 26,
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_clr,
  input  logic               at_max,
  output logic               count_en,
  output logic               count_clr,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  localparam logic [DIV_W-1:0] PCNT_LAST = DIV_W'(DIV - 1);

  logic             run_pulse;
  logic             clr_pulse;
  logic             tick;
  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] pcnt_q;
  logic [DIV_W-1:0] pcnt_d;
  logic             count_en_q;
  logic             count_en_d;
  logic             count_clr_q;
  logic             count_clr_d;

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_run_sync (
    .clock(clock),
    .reset(reset),
    .din  (btn_run),
    .pulse(run_pulse)
  );

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clr_sync (
    .clock(clock),
    .reset(reset),
    .din  (btn_clr),
    .pulse(clr_pulse)
  );

  always_comb begin
    tick = (state_q == ST_RUN) && (pcnt_q == PCNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
    end
  end

  // The prescaler is only touched from RUN or on a clear, so PAUSE keeps the partial period.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    if (clr_pulse) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_pulse) begin
            state_d = ST_RUN;
            pcnt_d  = '0;
          end
        end
        ST_RUN: begin
          if (run_pulse) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            pcnt_d = '0;
            if (at_max && !WRAP) begin
              state_d = ST_DONE;
            end
          end else begin
            pcnt_d = pcnt_q + DIV_W'(1);
          end
        end
        ST_PAUSE: begin
          if (run_pulse) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    count_clr_d = clr_pulse;
    count_en_d  = !clr_pulse && !run_pulse && tick && (WRAP || !at_max);
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign running   = (state_q == ST_RUN);
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_run_ctrl.sv
// ---- tb_tdc_run_ctrl : bench for the run controller, stop-at-99 and wrap variants  (rev 1.0) ----
`default_nettype none

module tb_tdc_run_ctrl;
  import tdc_pkg::*;

  localparam int DIV = 4;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       at_max  = 1'b0;
  logic       count_en, count_clr, running;
  logic [1:0] state;
  logic       count_en_w, count_clr_w, running_w;
  logic [1:0] state_w;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int tick_ph  = 0;
  int mon_e;
  int exp_q[$];

  tdc_run_ctrl #(.DIV(DIV), .DIV_W(3), .SYNC_STAGES(2), .WRAP(1'b0)) dut (
    .clock(clock), .reset(reset), .btn_run(btn_run), .btn_clr(btn_clr), .at_max(at_max),
    .count_en(count_en), .count_clr(count_clr), .running(running), .state(state)
  );

  tdc_run_ctrl #(.DIV(DIV), .DIV_W(3), .SYNC_STAGES(2), .WRAP(1'b1)) dut_w (
    .clock(clock), .reset(reset), .btn_run(btn_run), .btn_clr(btn_clr), .at_max(at_max),
    .count_en(count_en_w), .count_clr(count_clr_w), .running(running_w), .state(state_w)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Every count_en pulse of the stop-at-99 instance must match the next scheduled edge.
  always @(negedge clock) begin
    if (count_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL count_en_sched: got pulse at edge %0d, required no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          n_fail++;
          $display("FAIL count_en_sched: got pulse at edge %0d, required edge %0d", cyc, mon_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Called on a negedge; returns the edge on which the controller acts on the press.
  task automatic press(input logic r, input logic c, output int act);
    act     = cyc + 3;
    btn_run = r;
    btn_clr = c;
    @(negedge clock);
    btn_run = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %b required %b", state, ST_IDLE); end
    n_checks++; if (count_en !== 1'b0) begin n_fail++; $display("FAIL reset_count_en: got %b required 0", count_en); end
    n_checks++; if (count_clr !== 1'b0) begin n_fail++; $display("FAIL reset_count_clr: got %b required 0", count_clr); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b required 0", running); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_checks++;
      if (count_en !== 1'b0 || state !== ST_IDLE) begin
        n_fail++;
        $display("FAIL idle_quiet: got count_en=%b state=%b required 0/00", count_en, state);
      end
    end
  endtask

  task automatic test_run();
    int a;
    press(1'b1, 1'b0, a);
    goto(a - 1);
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL run_latency_early: got %b required %b", state, ST_IDLE); end
    goto(a);
    n_checks++; if (state !== ST_RUN || running !== 1'b1) begin n_fail++; $display("FAIL run_entry: got state=%b running=%b required 01/1", state, running); end
    for (int k = 1; k <= 5; k++) exp_q.push_back(a + DIV * k);
    tick_ph = a;
    goto(a + 20);
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL run_pulse_count: got %0d missing pulses required 0", exp_q.size()); end
  endtask

  task automatic test_pause();
    int c, p, r;
    c = tick_ph;
    while (c < cyc) c += DIV;
    for (int t = tick_ph; t <= c; t += DIV) if (t > cyc) exp_q.push_back(t);
    goto(c);
    press(1'b1, 1'b0, p);
    goto(p);
    n_checks++; if (state !== ST_PAUSE || running !== 1'b0) begin n_fail++; $display("FAIL pause_entry: got state=%b running=%b required 10/0", state, running); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++; if (state !== ST_PAUSE) begin n_fail++; $display("FAIL pause_hold: got %b required %b", state, ST_PAUSE); end
    end
    press(1'b1, 1'b0, r);
    goto(r);
    n_checks++; if (state !== ST_RUN) begin n_fail++; $display("FAIL resume_entry: got %b required %b", state, ST_RUN); end
    exp_q.push_back(r + 2);
    exp_q.push_back(r + 2 + DIV);
    tick_ph = r + 2;
    goto(r + 2 + DIV);
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL resume_pulses: got %0d missing pulses required 0", exp_q.size()); end
  endtask

  task automatic test_done_wrap();
    int t, d, k;
    t = tick_ph;
    while (t <= cyc) t += DIV;
    at_max = 1'b1;
    goto(t);
    n_checks++; if (state !== ST_DONE || running !== 1'b0) begin n_fail++; $display("FAIL done_entry: got state=%b running=%b required 11/0", state, running); end
    n_checks++; if (count_en !== 1'b0) begin n_fail++; $display("FAIL done_no_count: got %b required 0", count_en); end
    n_checks++; if (count_en_w !== 1'b1) begin n_fail++; $display("FAIL wrap_count_en: got %b required 1", count_en_w); end
    n_checks++; if (state_w !== ST_RUN) begin n_fail++; $display("FAIL wrap_state: got %b required %b", state_w, ST_RUN); end
    at_max = 1'b0;
    for (int i = 0; i < 2; i++) begin
      press(1'b1, 1'b0, d);
      goto(d);
      n_checks++; if (state !== ST_DONE) begin n_fail++; $display("FAIL done_ignores_run: got %b required %b", state, ST_DONE); end
    end
    press(1'b0, 1'b1, k);
    goto(k - 1);
    n_checks++; if (count_clr !== 1'b0) begin n_fail++; $display("FAIL clr_early: got %b required 0", count_clr); end
    goto(k);
    n_checks++; if (count_clr !== 1'b1 || count_en !== 1'b0) begin n_fail++; $display("FAIL clr_pulse: got clr=%b en=%b required 1/0", count_clr, count_en); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL clr_state: got %b required %b", state, ST_IDLE); end
    @(negedge clock);
    n_checks++; if (count_clr !== 1'b0) begin n_fail++; $display("FAIL clr_width: got %b required 0", count_clr); end
  endtask

  task automatic test_back_to_back();
    int a, k, e;
    press(1'b1, 1'b0, a);
    exp_q.push_back(a + DIV);
    exp_q.push_back(a + 2 * DIV);
    goto(a + 9);
    press(1'b1, 1'b1, k);
    goto(k);
    n_checks++; if (count_clr !== 1'b1 || count_en !== 1'b0) begin n_fail++; $display("FAIL both_btn_outputs: got clr=%b en=%b required 1/0", count_clr, count_en); end
    n_checks++; if (state !== ST_IDLE || running !== 1'b0) begin n_fail++; $display("FAIL both_btn_state: got state=%b running=%b required 00/0", state, running); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pre_clear_pulses: got %0d missing pulses required 0", exp_q.size()); end
    press(1'b1, 1'b0, e);
    exp_q.push_back(e + DIV);
    exp_q.push_back(e + 2 * DIV);
    goto(e + 3 * DIV - 1);
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (count_en !== 1'b0 || count_clr !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_strobes: got en=%b clr=%b required 0/0", count_en, count_clr); end
    n_checks++; if (state !== ST_IDLE || running !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_state: got state=%b running=%b required 00/0", state, running); end
    n_checks++; if (state_w !== ST_IDLE) begin n_fail++; $display("FAIL midrun_reset_wrap: got %b required %b", state_w, ST_IDLE); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL post_clear_phase: got %0d missing pulses required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_done_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
